// File: rtl/mem_copy_dma.sv
// Word-granular memory-to-memory copy engine; bus initiator on a single-port memory.
// Optional build macro DMA_FILL_EN adds a pattern-fill mode (fill, fill_value).
module mem_copy_dma #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] length,
`ifdef DMA_FILL_EN
  input  logic                 fill,
  input  logic [31:0]          fill_value,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 memory_read,
  output logic                 memory_write,
  output logic [31:0]          address,
  output logic [31:0]          write_data,
  input  logic [31:0]          read_data
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3
`ifdef DMA_FILL_EN
    ,FILL = 3'd4
`endif
  } state_e;

  localparam logic [LEN_WIDTH-1:0] CNT_ONE = LEN_WIDTH'(1);

  state_e               state_q, state_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          buf_q, buf_d;
  logic                 err_q, err_d;
  logic                 misalign;
  logic                 fill_req;
`ifdef DMA_FILL_EN
  logic [31:0]          fval_q, fval_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
`ifdef DMA_FILL_EN
      fval_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
`ifdef DMA_FILL_EN
      fval_q  <= fval_d;
`endif
    end
  end

  // Fill never reads, so only the destination has to be aligned in that mode.
`ifdef DMA_FILL_EN
  assign fill_req = fill;
`else
  assign fill_req = 1'b0;
`endif
  assign misalign = (dst_addr[1:0] != 2'b00) || (!fill_req && (src_addr[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = 1'b0;
`ifdef DMA_FILL_EN
    fval_d  = fval_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (misalign) begin
            err_d = 1'b1;
          end else if (length == '0) begin
            state_d = DONE;
          end else begin
            src_d = src_addr;
            dst_d = dst_addr;
            cnt_d = length;
`ifdef DMA_FILL_EN
            fval_d  = fill_value;
            state_d = fill ? FILL : READ;
`else
            state_d = READ;
`endif
          end
        end
      end
      READ: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          buf_d   = read_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // On abort the write strobe of this cycle still lands; pointers stay stale.
        if (abort) begin
          state_d = IDLE;
        end else begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          cnt_d   = cnt_q - CNT_ONE;
          state_d = (cnt_q == CNT_ONE) ? DONE : READ;
        end
      end
`ifdef DMA_FILL_EN
      FILL: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          dst_d   = dst_q + 32'd4;
          cnt_d   = cnt_q - CNT_ONE;
          state_d = (cnt_q == CNT_ONE) ? DONE : FILL;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus side is a pure decode of state and registers.
  always_comb begin
    busy         = 1'b0;
    memory_read  = 1'b0;
    memory_write = 1'b0;
    address      = '0;
    write_data   = '0;
    case (state_q)
      READ: begin
        busy        = 1'b1;
        memory_read = 1'b1;
        address     = src_q;
      end
      WRITE: begin
        busy         = 1'b1;
        memory_write = 1'b1;
        address      = dst_q;
        write_data   = buf_q;
      end
`ifdef DMA_FILL_EN
      FILL: begin
        busy         = 1'b1;
        memory_write = 1'b1;
        address      = dst_q;
        write_data   = fval_q;
      end
`endif
      default: ;
    endcase
  end

  assign done  = (state_q == DONE);
  assign error = err_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma with a word memory model and bus-strobe monitors.
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] length = '0;
`ifdef DMA_FILL_EN
  logic        fill = 1'b0;
  logic [31:0] fill_value = '0;
`endif
  logic        busy, done, error, memory_read, memory_write;
  logic [31:0] address, write_data, read_data;

  logic [31:0] mem [0:1023];
  logic        tb_we = 1'b0;
  logic [31:0] tb_wa = '0;
  logic [31:0] tb_wd = '0;

  int n_chk = 0;
  int n_err = 0;
  int rd_cnt = 0, wr_cnt = 0, alt_err = 0, ovl_cnt = 0, last_op = 0;

  mem_copy_dma #(.LEN_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
`ifdef DMA_FILL_EN
    .fill(fill), .fill_value(fill_value),
`endif
    .busy(busy), .done(done), .error(error),
    .memory_read(memory_read), .memory_write(memory_write),
    .address(address), .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  assign read_data = mem[address[11:2]];

  // Memory model plus strobe monitors; back-to-back same-kind strobes flag broken alternation.
  always @(posedge clk) begin
    if (memory_write) mem[address[11:2]] <= write_data;
    else if (tb_we)   mem[tb_wa[11:2]]   <= tb_wd;
    if (memory_read && memory_write) ovl_cnt <= ovl_cnt + 1;
    if (memory_read) begin
      rd_cnt <= rd_cnt + 1;
      if (last_op == 1) alt_err <= alt_err + 1;
      last_op <= 1;
    end
    if (memory_write) begin
      wr_cnt <= wr_cnt + 1;
`ifdef DMA_FILL_EN
      if (!fill) begin
        if (last_op == 2) alt_err <= alt_err + 1;
        last_op <= 2;
      end
`else
      if (last_op == 2) alt_err <= alt_err + 1;
      last_op <= 2;
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] peek(input logic [31:0] a);
    return mem[a[11:2]];
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Starts a transfer and watches up to 60 cycles; lat is the cycle count to done (0 = none).
  task automatic do_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                         input int abort_at, input int restart_at,
                         output int lat, output int bcyc, output int rd, output int wr,
                         output int alt);
    int r0, w0, a0;
    r0 = rd_cnt; w0 = wr_cnt; a0 = alt_err;
    @(negedge clk);
    src_addr = s; dst_addr = d; length = n; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; bcyc = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      abort = 1'b0; start = 1'b0; length = n;
      if (busy) bcyc++;
      if (done) begin lat = c; break; end
      if (c == abort_at) abort = 1'b1;
      if (c == restart_at) begin start = 1'b1; length = 16'd7; end
    end
    rd = rd_cnt - r0; wr = wr_cnt - w0; alt = alt_err - a0;
  endtask

  int lat, bcyc, rd, wr, alt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_strobes", {30'd0, memory_read, memory_write}, 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_wdata", write_data, 32'd0);
    rst_n = 1'b1;

    // Basic 4-word copy
    poke(32'h100, 32'd11); poke(32'h104, 32'd22);
    poke(32'h108, 32'd33); poke(32'h10C, 32'd44);
    do_xfer(32'h100, 32'h200, 16'd4, 0, 0, lat, bcyc, rd, wr, alt);
    chk("cp4_latency", lat, 32'd9);
    chk("cp4_busy_cycles", bcyc, 32'd8);
    chk("cp4_reads", rd, 32'd4);
    chk("cp4_writes", wr, 32'd4);
    chk("cp4_alternate", alt, 32'd0);
    chk("cp4_w0", peek(32'h200), 32'd11);
    chk("cp4_w1", peek(32'h204), 32'd22);
    chk("cp4_w2", peek(32'h208), 32'd33);
    chk("cp4_w3", peek(32'h20C), 32'd44);
    @(negedge clk);
    chk("cp4_done_pulse", {31'd0, done}, 32'd0);

    // Misaligned source: error pulse, no bus activity
    rd = rd_cnt; wr = wr_cnt;
    @(negedge clk);
    src_addr = 32'h102; dst_addr = 32'h200; length = 16'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("mis_error", {31'd0, error}, 32'd1);
    chk("mis_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("mis_error_pulse", {31'd0, error}, 32'd0);
    chk("mis_busy2", {31'd0, busy}, 32'd0);
    chk("mis_no_bus", (rd_cnt - rd) + (wr_cnt - wr), 32'd0);

    // Misaligned destination also rejected
    @(negedge clk);
    src_addr = 32'h100; dst_addr = 32'h201; length = 16'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("misd_error", {31'd0, error}, 32'd1);

    // Zero length
    do_xfer(32'h100, 32'h200, 16'd0, 0, 0, lat, bcyc, rd, wr, alt);
    chk("len0_latency", lat, 32'd1);
    chk("len0_no_bus", rd + wr, 32'd0);

    // Abort during third WRITE of an 8-word copy
    for (int i = 0; i < 8; i++) poke(32'h400 + 4 * i, 32'hA0 + i);
    poke(32'h50C, 32'd0);
    do_xfer(32'h400, 32'h500, 16'd8, 6, 0, lat, bcyc, rd, wr, alt);
    chk("abt_no_done", lat, 32'd0);
    chk("abt_writes", wr, 32'd3);
    chk("abt_reads", rd, 32'd3);
    chk("abt_busy_cycles", bcyc, 32'd6);
    chk("abt_idle", {31'd0, busy}, 32'd0);
    chk("abt_w2", peek(32'h508), 32'hA2);
    chk("abt_w3_untouched", peek(32'h50C), 32'd0);
    do_xfer(32'h400, 32'h600, 16'd2, 0, 0, lat, bcyc, rd, wr, alt);
    chk("abt_restart_latency", lat, 32'd5);
    chk("abt_restart_w1", peek(32'h604), 32'hA1);

    // Start while busy is ignored
    do_xfer(32'h100, 32'h240, 16'd3, 0, 2, lat, bcyc, rd, wr, alt);
    chk("ign_latency", lat, 32'd7);
    chk("ign_writes", wr, 32'd3);
    chk("ign_w2", peek(32'h248), 32'd33);

    // Reset during READ of word 2
    poke(32'h700, 32'd5); poke(32'h704, 32'd6); poke(32'h708, 32'd7);
    poke(32'h800, 32'd0); poke(32'h804, 32'd0);
    @(negedge clk);
    src_addr = 32'h700; dst_addr = 32'h800; length = 16'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rmid_reading", {31'd0, memory_read}, 32'd1);
    chk("rmid_addr", address, 32'h704);
    rst_n = 1'b0;
    #1;
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    chk("rmid_read", {31'd0, memory_read}, 32'd0);
    chk("rmid_address", address, 32'd0);
    @(negedge clk);
    chk("rmid_w0", peek(32'h800), 32'd5);
    chk("rmid_w1_lost", peek(32'h804), 32'd0);
    rst_n = 1'b1;

`ifdef DMA_FILL_EN
    @(negedge clk);
    fill = 1'b1; fill_value = 32'hDEADBEEF;
    do_xfer(32'h101, 32'h300, 16'd5, 0, 0, lat, bcyc, rd, wr, alt);
    chk("fill_latency", lat, 32'd6);
    chk("fill_busy_cycles", bcyc, 32'd5);
    chk("fill_reads", rd, 32'd0);
    chk("fill_writes", wr, 32'd5);
    for (int i = 0; i < 5; i++) chk("fill_word", peek(32'h300 + 4 * i), 32'hDEADBEEF);
    @(negedge clk);
    fill = 1'b0;
`endif

    chk("no_overlap", ovl_cnt, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
